// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller.
//   evt_type_e : event kind carried through pending slots and the FIFO
//   evt_t      : one FIFO entry, {button id, event kind}
package btn_evt_pkg;

  // Wide enough for up to 16 buttons; the top narrows it to $clog2(NUM_BTN).
  localparam int unsigned EVT_ID_W = 4;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_type_e;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    evt_type_e           kind;
  } evt_t;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event stream between the controller and its consumer.
//   evt_valid : head event present (producer)
//   evt_ready : consumer accepts head when evt_valid=1
//   evt_id    : button index of head event
//   evt_type  : 01=PRESS 10=RELEASE 11=LONG
interface button_event_ctrl_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_type;

  modport master (output evt_valid, evt_id, evt_type, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_type, output evt_ready);
endinterface

// File: rtl/btn_evt_fifo.sv
// Synchronous show-ahead FIFO of evt_t.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop head (ignored when empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_data     : current head (valid while !o_empty)
module btn_evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  evt_t i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output evt_t o_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  evt_t        r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_push;
  logic        w_pop;

  // Extra MSB on the pointers tells full (MSBs differ) from empty (equal).
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter.
//   clk, rst_n : clock, async active-low reset
//   i_raw      : asynchronous button level
//   o_level    : debounced level; flips only after the synced input has
//                differed from it for DEBOUNCE_COUNT consecutive cycles
module sync_debounce #(
  parameter int unsigned DEBOUNCE_COUNT = 1000,
  parameter int unsigned COUNTER_WIDTH  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_COUNT - 1);

  logic [1:0]               r_sync;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic                     r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/button_event_ctrl.sv
// Front-end controller for NUM_BTN push-buttons: debounce, edge/long-press
// detection, per-button pending slot, round-robin arbitration into a FIFO.
//   clk, rst_n   : clock, async active-low reset
//   btn_a        : raw asynchronous button levels
//   btn_state    : debounced levels
//   evt          : event stream (valid/ready, id, type) of the FIFO head
//   overflow     : sticky, an event was dropped on an occupied pending slot
//   clr_overflow : one-cycle pulse clearing overflow (a same-cycle drop wins)
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned NUM_BTN           = 4,
  parameter int unsigned DEBOUNCE_COUNT    = 1000,
  parameter int unsigned COUNTER_WIDTH     = 10,
  parameter int unsigned LONG_PRESS_CYCLES = 50000,
  parameter int unsigned LP_WIDTH          = 16,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         btn_a,
  output logic [NUM_BTN-1:0]         btn_state,
  button_event_ctrl_if.master        evt,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int unsigned ID_W = $clog2(NUM_BTN);
  localparam logic [LP_WIDTH-1:0] LP_MAX  = LP_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [LP_WIDTH-1:0] LP_LAST = LP_WIDTH'(LONG_PRESS_CYCLES - 1);

  logic [NUM_BTN-1:0]  r_prev;
  logic [LP_WIDTH-1:0] r_lp   [NUM_BTN];
  evt_type_e           r_pend [NUM_BTN];
  logic [ID_W-1:0]     r_rr;
  logic                r_ovf;

  logic [NUM_BTN-1:0]  w_rise;
  logic [NUM_BTN-1:0]  w_fall;
  logic [NUM_BTN-1:0]  w_long;
  logic [NUM_BTN-1:0]  w_drop;
  logic [NUM_BTN-1:0]  w_gnt;
  evt_type_e           w_new  [NUM_BTN];
  logic                w_gnt_vld;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_full;
  logic                w_empty;
  evt_t                w_wdata;
  evt_t                w_head;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    sync_debounce #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (btn_a[g]),
      .o_level(btn_state[g])
    );
  end

  // Round-robin: scan from r_rr, first occupied slot wins; nothing while full.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      idx = (32'(r_rr) + k) % NUM_BTN;
      if (!w_gnt_vld && !w_full && (r_pend[idx] != EVT_NONE)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'(idx);
      end
    end
  end

  // A granted slot may take a new event in the same cycle without a drop.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      w_rise[i] = btn_state[i] && !r_prev[i];
      w_fall[i] = !btn_state[i] && r_prev[i];
      w_long[i] = btn_state[i] && r_prev[i] && (r_lp[i] == LP_LAST);
      w_gnt[i]  = w_gnt_vld && (w_gnt_idx == ID_W'(i));
      if (w_rise[i])      w_new[i] = EVT_PRESS;
      else if (w_fall[i]) w_new[i] = EVT_RELEASE;
      else if (w_long[i]) w_new[i] = EVT_LONG;
      else                w_new[i] = EVT_NONE;
      w_drop[i] = (w_new[i] != EVT_NONE) && (r_pend[i] != EVT_NONE) && !w_gnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_rr   <= '0;
      r_ovf  <= 1'b0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        r_lp[i]   <= '0;
        r_pend[i] <= EVT_NONE;
      end
    end else begin
      r_prev <= btn_state;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        // Timer saturates at LP_MAX so LONG fires once per press.
        if (w_rise[i] || w_fall[i])               r_lp[i] <= '0;
        else if (btn_state[i] && r_lp[i] != LP_MAX) r_lp[i] <= r_lp[i] + 1'b1;

        if ((w_new[i] != EVT_NONE) && !w_drop[i]) r_pend[i] <= w_new[i];
        else if (w_gnt[i])                        r_pend[i] <= EVT_NONE;
      end
      if (w_gnt_vld)
        r_rr <= (w_gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (|w_drop)           r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  assign w_wdata = '{id: EVT_ID_W'(w_gnt_idx), kind: r_pend[w_gnt_idx]};

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_gnt_vld),
    .i_data (w_wdata),
    .i_pop  (evt.evt_ready),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_data (w_head)
  );

  // Head contents are masked while empty so stale memory never shows.
  assign evt.evt_valid = !w_empty;
  assign evt.evt_id    = w_empty ? '0 : ID_W'(w_head.id);
  assign evt.evt_type  = w_empty ? '0 : w_head.kind;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;

  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_a;
  logic [NB-1:0] btn_state;
  logic          overflow;
  logic          clr_overflow;
  int            cyc;

  button_event_ctrl_if #(.ID_W(2)) bus ();

  button_event_ctrl #(
    .NUM_BTN          (NB),
    .DEBOUNCE_COUNT   (4),
    .COUNTER_WIDTH    (10),
    .LONG_PRESS_CYCLES(20),
    .LP_WIDTH         (16),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_a       (btn_a),
    .btn_state   (btn_state),
    .evt         (bus),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  typedef struct {
    int id;
    int typ;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   n_checks;
  int   n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void exp_push(input int id, input int typ);
    exp_t e;
    e.id  = id;
    e.typ = typ;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor: every accepted event is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got id=%0d type=%0d, expected none (cycle %0d)",
                 bus.evt_id, bus.evt_type, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_id", int'(bus.evt_id), e.id);
        check("evt_type", int'(bus.evt_type), e.typ);
      end
      acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_btn(input int b, input logic lvl, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (btn_state[b] !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("btn_state_wait", (btn_state[b] === lvl) ? 1 : 0, 1);
    t = cyc;
  endtask

  task automatic wait_drain(input string name, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    cycles(1);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, int'(bus.evt_valid), 0);
    check({tag, "_id"}, int'(bus.evt_id), 0);
    check({tag, "_type"}, int'(bus.evt_type), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_state"}, int'(btn_state), 0);
  endtask

  initial begin
    int t0;
    int t_rise;
    int t_dummy;
    int hi;

    rst_n         = 1'b0;
    btn_a         = '0;
    clr_overflow  = 1'b0;
    bus.evt_ready = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // 1: single press on button 1
    bus.evt_ready = 1'b1;
    acc_cyc.delete();
    exp_push(1, 1);
    exp_push(1, 2);
    cycles(1);
    btn_a[1] = 1'b1;
    t0 = cyc;
    wait_btn(1, 1'b1, t_rise);
    check("debounce_latency", t_rise - t0, 6);
    cycles(4);
    btn_a[1] = 1'b0;
    wait_btn(1, 1'b0, t_dummy);
    wait_drain("t1_drain", 60);
    cycles(5);
    check("t1_count", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2) begin
      check("t1_press_latency", acc_cyc[0] - t_rise, 2);
      check("t1_press_single", (acc_cyc[1] - acc_cyc[0] > 1) ? 1 : 0, 1);
    end

    // 2: long press on button 2
    acc_cyc.delete();
    exp_push(2, 1);
    exp_push(2, 3);
    exp_push(2, 2);
    btn_a[2] = 1'b1;
    cycles(40);
    btn_a[2] = 1'b0;
    wait_drain("t2_drain", 60);
    cycles(10);
    check("t2_count", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 2)
      check("t2_long_delay", acc_cyc[1] - acc_cyc[0], 20);

    // 3: glitching input on button 0 never passes the debouncer
    acc_cyc.delete();
    hi = 0;
    for (int t = 0; t < 30; t++) begin
      btn_a[0] = (t % 3 != 2);
      @(negedge clk);
      if (btn_state[0]) hi++;
      cycles(1);
    end
    btn_a[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (btn_state[0]) hi++;
    end
    check("t3_glitch_state", hi, 0);
    check("t3_no_events", acc_cyc.size(), 0);

    // 4: all buttons at once, round-robin from a fresh pointer
    do_reset();
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) exp_push(i, 1);
    btn_a = 4'hF;
    wait_drain("t4_press_drain", 40);
    check("t4_count", acc_cyc.size(), 4);
    if (acc_cyc.size() >= 4)
      check("t4_consecutive", acc_cyc[3] - acc_cyc[0], 3);
    cycles(1);
    for (int i = 0; i < 4; i++) exp_push(i, 2);
    btn_a = 4'h0;
    wait_drain("t4_release_drain", 40);

    // 5: FIFO fills, one pending, one dropped
    cycles(2);
    bus.evt_ready = 1'b0;
    acc_cyc.delete();
    exp_push(3, 1);
    exp_push(3, 2);
    exp_push(3, 1);
    exp_push(3, 2);
    exp_push(3, 1);
    for (int k = 0; k < 6; k++) begin
      btn_a[3] = (k % 2 == 0);
      cycles(8);
    end
    cycles(4);
    check("t5_overflow_set", int'(overflow), 1);
    check("t5_valid_full", int'(bus.evt_valid), 1);
    check("t5_head_id", int'(bus.evt_id), 3);
    check("t5_head_type", int'(bus.evt_type), 1);
    bus.evt_ready = 1'b1;
    wait_drain("t5_drain", 40);
    cycles(5);
    check("t5_count", acc_cyc.size(), 5);
    check("t5_overflow_held", int'(overflow), 1);
    clr_overflow = 1'b1;
    cycles(1);
    clr_overflow = 1'b0;
    @(negedge clk);
    check("t5_overflow_clr", int'(overflow), 0);

    // 6: reset with events queued and button 1 held
    cycles(1);
    bus.evt_ready = 1'b0;
    acc_cyc.delete();
    btn_a[0] = 1'b1;
    cycles(8);
    btn_a[0] = 1'b0;
    cycles(10);
    check("t6_queued", int'(bus.evt_valid), 1);
    btn_a[1] = 1'b1;
    cycles(2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    cycles(3);
    rst_n = 1'b1;
    exp_push(1, 1);
    bus.evt_ready = 1'b1;
    wait_drain("t6_press_drain", 40);
    check("t6_count", acc_cyc.size(), 1);
    cycles(1);
    exp_push(1, 2);
    btn_a[1] = 1'b0;
    wait_drain("t6_release_drain", 40);
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
